// File: rtl/dfi_cmd_recorder_pkg.sv
// Shared softMC instruction layout for the DFI command recorder.
// Field positions and type codes live here so the encoder never uses raw bit numbers.
package dfi_cmd_recorder_pkg;

  localparam int INSTR_W     = 32;
  localparam int TYPE_OFFSET = 28;
  localparam int TYPE_W      = 4;

  localparam logic [TYPE_W-1:0] INSTR_TYPE_WAIT = 4'd0;
  localparam logic [TYPE_W-1:0] INSTR_TYPE_DDR  = 4'd1;

  // DDR word layout: row bits from 0, bank at ROW_OFFSET, then WE/CAS/RAS, then CS.
  localparam int ROW_OFFSET = 16;
  localparam int WE_OFFSET  = 19;
  localparam int CAS_OFFSET = 20;
  localparam int RAS_OFFSET = 21;
  localparam int CS_OFFSET  = 22;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } rec_state_e;

  function automatic logic [INSTR_W-1:0] wait_word(input logic [TYPE_OFFSET-1:0] n);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[TYPE_OFFSET +: TYPE_W] = INSTR_TYPE_WAIT;
    w[TYPE_OFFSET-1:0]       = n;
    return w;
  endfunction

endpackage

// File: rtl/dfi_cmd_recorder_fifo.sv
// trace_fifo2w: FIFO accepting zero, one or two words per cycle and releasing one.
// A two-word write is all-or-nothing so a WAIT is never separated from its command.
module trace_fifo2w #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic         wr_pair,
  input  logic [W-1:0] wr_data0,
  input  logic [W-1:0] wr_data1,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         wr_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop, accept;
  logic [1:0]    wr_num;
  logic [AW+1:0] need;

  assign pop    = rd_en && (count_reg != '0);
  assign wr_num = wr_en ? (wr_pair ? 2'd2 : 2'd1) : 2'd0;
  // Space is judged after this cycle's pop, so a full FIFO being read can still take a word.
  assign need   = (AW+2)'(count_reg) - (AW+2)'(pop) + (AW+2)'(wr_num);
  assign accept = wr_en && (need <= (AW+2)'(DEPTH));
  assign wr_drop = wr_en && !accept;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= wr_data0;
      if (wr_pair) mem[wr_ptr_reg + 1'b1] <= wr_data1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + AW'(wr_num);
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg - (AW+1)'(pop) + (accept ? (AW+1)'(wr_num) : '0);
    end
  end

  assign rd_valid = (count_reg != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/dfi_cmd_recorder.sv
// Snoops DFI slot 0 and re-encodes issued commands as softMC words, with idle
// gaps folded into WAIT words, buffered in a dual-write trace FIFO.
module dfi_cmd_recorder
  import dfi_cmd_recorder_pkg::*;
#(
  parameter int ROW_WIDTH  = 15,
  parameter int BANK_WIDTH = 3,
  parameter int CS_WIDTH   = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int WAIT_W     = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [ROW_WIDTH*8-1:0]  dfi_address,
  input  logic [BANK_WIDTH*8-1:0] dfi_bank,
  input  logic                    dfi_ras_n,
  input  logic                    dfi_cas_n,
  input  logic                    dfi_we_n,
  input  logic [7:0]              dfi_cs_n,
  input  logic [7:0]              mc_ACT_n,
  output logic [31:0]             instr_out,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic                    overflow
);

  localparam int ADDR_BITS = ROW_WIDTH - 3;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  logic [ADDR_BITS-1:0]  addr_s0;
  logic [BANK_WIDTH-1:0] bank_s0;

  for (genvar gi = 0; gi < ADDR_BITS; gi++) begin : g_addr
    assign addr_s0[gi] = dfi_address[8*gi];
  end
  for (genvar gi = 0; gi < BANK_WIDTH; gi++) begin : g_bank
    assign bank_s0[gi] = dfi_bank[8*gi];
  end

  logic unused_inputs;
  assign unused_inputs = ^{dfi_address, dfi_bank, dfi_cs_n, mc_ACT_n};

  logic        is_act, cmd_cycle;
  logic [31:0] cmd_word;

  assign is_act    = (mc_ACT_n[1:0] == 2'b00);
  assign cmd_cycle = en && !dfi_cs_n[0];

  always_comb begin
    cmd_word = '0;
    cmd_word[TYPE_OFFSET +: TYPE_W]   = INSTR_TYPE_DDR;
    cmd_word[CS_OFFSET +: CS_WIDTH]   = dfi_cs_n[CS_WIDTH-1:0];
    cmd_word[ROW_OFFSET +: BANK_WIDTH] = bank_s0;
    cmd_word[ADDR_BITS-1:0]           = addr_s0;
    cmd_word[RAS_OFFSET] = is_act ? 1'b0 : dfi_ras_n;
    cmd_word[CAS_OFFSET] = is_act ? 1'b1 : dfi_cas_n;
    cmd_word[WE_OFFSET]  = is_act ? 1'b1 : dfi_we_n;
  end

  rec_state_e        state_reg, state_next;
  logic [WAIT_W-1:0] count_reg, count_next;
  logic [TYPE_OFFSET-1:0] count_ext, max_ext;

  always_comb begin
    count_ext = '0;
    count_ext[WAIT_W-1:0] = count_reg;
    max_ext = '0;
    max_ext[WAIT_W-1:0] = WAIT_MAX;
  end

  logic        push_en, push_pair;
  logic [31:0] push_d0, push_d1;

  // ST_COUNT means a nonzero idle run is pending and must be flushed as a WAIT.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    push_en    = 1'b0;
    push_pair  = 1'b0;
    push_d0    = cmd_word;
    push_d1    = cmd_word;
    if (cmd_cycle) begin
      push_en    = 1'b1;
      count_next = '0;
      state_next = ST_IDLE;
      if (state_reg == ST_COUNT) begin
        push_pair = 1'b1;
        push_d0   = wait_word(count_ext);
      end
    end else if (en) begin
      if (count_reg == WAIT_MAX - 1'b1) begin
        push_en    = 1'b1;
        push_d0    = wait_word(max_ext);
        count_next = '0;
        state_next = ST_IDLE;
      end else begin
        count_next = count_reg + 1'b1;
        state_next = ST_COUNT;
      end
    end else begin
      count_next = '0;
      state_next = ST_IDLE;
      if (state_reg == ST_COUNT) begin
        push_en = 1'b1;
        push_d0 = wait_word(count_ext);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  logic wr_drop;

  trace_fifo2w #(
    .DEPTH(FIFO_DEPTH),
    .W    (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_en),
    .wr_pair (push_pair),
    .wr_data0(push_d0),
    .wr_data1(push_d1),
    .rd_en   (instr_ready),
    .rd_data (instr_out),
    .rd_valid(instr_valid),
    .wr_drop (wr_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (wr_drop) overflow <= 1'b1;
  end

endmodule
